// File: rtl/if_scratch_writer_pkg.sv
// Shared types and helpers for the IF scratchpad writer and its read-side checker.
package if_scratch_pkg;

  localparam int IF_CELL_SIZE_D    = 8;
  localparam int IF_ADDRESS_SIZE_D = 8;
  localparam int CELL_NUMS_IF_D    = 8;
  localparam int FRAME_LEN_SIZE_D  = 16;

  typedef enum logic [1:0] {IDLE, FILL, DONE} wr_state_e;

  // Circular increment by compare-and-zero, so non power-of-two depths need no divider.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/if_scratch_writer_if.sv
// Valid/ready stream carrying IF words into the scratchpad writer.
interface if_scratch_writer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/if_scratch_writer.sv
// Writes a streamed IF frame into the circular scratchpad and publishes the write pointer.
module if_scratch_writer
  import if_scratch_pkg::*;
#(
  parameter int IF_CELL_SIZE    = IF_CELL_SIZE_D,
  parameter int IF_ADDRESS_SIZE = IF_ADDRESS_SIZE_D,
  parameter int CELL_NUMS_IF    = CELL_NUMS_IF_D,
  parameter int FRAME_LEN_SIZE  = FRAME_LEN_SIZE_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 if_size,
  input  logic [FRAME_LEN_SIZE-1:0]  frame_len,
  if_scratch_writer_if.slave         in_s,
  input  logic [IF_ADDRESS_SIZE:0]   write_start,
  output logic                       scratch_write_en,
  output logic [IF_ADDRESS_SIZE:0]   write_addr_if,
  output logic [IF_CELL_SIZE-1:0]    write_data_if,
  output logic [IF_ADDRESS_SIZE-1:0] write_cnt_if,
  output logic                       row_last,
  output logic                       full,
  output logic                       busy,
  output logic                       done
);

  wr_state_e                  state_q, state_d;
  logic [IF_ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_nx;
  logic [2:0]                 if_size_q, col_cnt_q;
  logic [FRAME_LEN_SIZE-1:0]  remaining_q;
  logic [IF_ADDRESS_SIZE:0]   ws_mod;
  logic                       fill_ok, fire, col_last, load;

  assign wr_ptr_nx = IF_ADDRESS_SIZE'(next_ptr(32'(wr_ptr_q), CELL_NUMS_IF));
  assign ws_mod    = write_start % (IF_ADDRESS_SIZE+1)'(CELL_NUMS_IF);
  // One slot stays empty so a full ring is distinguishable from an empty one.
  assign full      = ({1'b0, wr_ptr_nx} == ws_mod);

  assign fill_ok   = (state_q == FILL) && !full;
  assign fire      = fill_ok && in_s.in_valid;
  assign col_last  = (col_cnt_q == if_size_q - 3'd1);
  assign load      = (state_q == IDLE) && start && (frame_len != '0);

  assign in_s.in_ready    = fill_ok;
  assign scratch_write_en = fire;
  assign write_addr_if    = {1'b0, wr_ptr_q};
  assign write_data_if    = fire ? in_s.in_data : '0;
  assign write_cnt_if     = wr_ptr_q;
  assign row_last         = fire && col_last;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (frame_len == '0) ? DONE : FILL;
      FILL: if (fire && remaining_q == FRAME_LEN_SIZE'(1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      col_cnt_q   <= '0;
      remaining_q <= '0;
      if_size_q   <= 3'd1;
    end else begin
      state_q <= state_d;
      if (load) begin
        if_size_q   <= (if_size == 3'd0) ? 3'd1 : if_size;
        remaining_q <= frame_len;
        col_cnt_q   <= '0;
      end else if (fire) begin
        wr_ptr_q    <= wr_ptr_nx;
        remaining_q <= remaining_q - FRAME_LEN_SIZE'(1);
        col_cnt_q   <= col_last ? 3'd0 : col_cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: doc/if_scratch_writer.md
Name: if_scratch_writer

Overview:
- Write-side producer for the circular input-feature (IF) scratchpad. The read-pointer checker consumes this scratchpad.
- Accepts IF words over a valid/ready stream and writes them into CELL_NUMS_IF circular cells.
- Publishes the write pointer (write_cnt_if) that the read side compares against.
- Stalls when the next write would overrun the oldest unreleased cell (write_start). One slot is always kept empty.

Parameters:
- IF_CELL_SIZE, 8, data width of one scratchpad cell.
- IF_ADDRESS_SIZE, 8, scratchpad address width.
- CELL_NUMS_IF, 8, number of cells in the circular buffer; must satisfy 2 <= CELL_NUMS_IF <= 2^IF_ADDRESS_SIZE.
- FRAME_LEN_SIZE, 16, width of the frame word counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins loading a frame. Honoured only in IDLE.
- if_size  in  3  row length in cells; latched on start.
- frame_len  in  FRAME_LEN_SIZE  number of words in the frame; latched on start.
- in_data  in  IF_CELL_SIZE  stream data.
- in_valid  in  1  stream valid.
- in_ready  out  1  stream ready.
- write_start  in  IF_ADDRESS_SIZE+1  oldest unreleased cell, driven by the read side; used modulo CELL_NUMS_IF.
- scratch_write_en  out  1  scratchpad write strobe.
- write_addr_if  out  IF_ADDRESS_SIZE+1  scratchpad write address.
- write_data_if  out  IF_CELL_SIZE  scratchpad write data.
- write_cnt_if  out  IF_ADDRESS_SIZE  next write position (wr_ptr).
- row_last  out  1  the current write is the last cell of a row.
- full  out  1  buffer full.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse after the last frame word is written.

Behaviour:
- Reset (asynchronous, rst=0):
  - FSM=IDLE; wr_ptr=0; col_cnt=0; remaining=0.
  - Latched if_size = 1.
  - All outputs 0, except write_cnt_if=0 and full, which is combinational from wr_ptr/write_start.
  - Reset mid-frame abandons the frame; no done pulse is emitted.
- full = ((wr_ptr+1 wrapped) == write_start mod CELL_NUMS_IF).
  - Pointer wrap is done by compare-and-zero, not a % operator.
- FSM states:
  - IDLE: in_ready=0.
    - On start with frame_len!=0: latch if_size (0 is treated as 1), set remaining=frame_len, col_cnt=0, go to FILL.
    - On start with frame_len==0: go to DONE.
  - FILL:
    - in_ready = !full.
    - fire = in_valid & in_ready.
    - On fire: remaining decrements.
    - When fire && remaining==1: go to DONE.
    - start is ignored in FILL.
  - DONE: done=1 for exactly one cycle, in_ready=0, then IDLE.
- Write port, combinational from fire (zero latency):
  - scratch_write_en = fire.
  - write_addr_if = zero-extended wr_ptr.
  - write_data_if = in_data.
  - The scratchpad captures the write on the same clock edge.
- On fire, at the edge:
  - wr_ptr <= wr_ptr+1, wrapping to 0 at CELL_NUMS_IF.
  - col_cnt <= (col_cnt == if_size-1) ? 0 : col_cnt+1.
- row_last = fire && col_cnt == if_size-1.
- write_cnt_if = wr_ptr register.
  - It advances the cycle after the write, so the read side never sees an unwritten cell as valid.
- wr_ptr and write_cnt_if persist across frames. Only rst clears them.
- Simultaneous events:
  - A write_start change in the same cycle as a fire is evaluated with the current write_start; the release is effective the next cycle.
  - full may deassert while in_valid is held. The transfer happens in the first cycle in which full=0.
- in_data and in_valid are don't-care outside FILL. in_ready=0 there.

Decomposition:
- Shared package if_scratch_pkg:
  - FSM state enum {IDLE, FILL, DONE}.
  - Pointer-wrap helper function next_ptr(ptr, N).
  - Default width constants shared with the read-side checker.
- No sub-module. One FSM plus three counters (wr_ptr, col_cnt, remaining) fit in a single module.

Test Plan:
- Reset: assert rst=0 mid-FILL with in_valid=1 → busy=0, in_ready=0, write_cnt_if=0, scratch_write_en=0, no done.
- Basic fill: CELL_NUMS_IF=8, write_start=0, start with frame_len=3 and if_size=3, in_valid held → 3 writes to addr 0,1,2; row_last on the 3rd; done one cycle later; write_cnt_if=3.
- Full stall: write_start=0, frame_len=10 → 7 writes (addr 0..6), then full=1 and in_ready=0. Set write_start=3 → writes resume at addr 7, 0, 1; full re-asserts with wr_ptr=2.
- Wrap: preload wr_ptr=6 via a prior frame, write_start=5, frame_len=6 → addresses 6, 7, 0, 1, 2, 3; full after addr 3 is written; write_cnt_if=4.
- Edge starts: frame_len=0 → done the next cycle with zero writes. if_size=0 → row_last on every write. start pulsed during FILL → ignored, remaining unchanged.
- Bubbles: in_valid toggled 1,0,1,0 with frame_len=2 → exactly 2 writes, each on an in_valid=1 cycle; done only after the 2nd.
